cpu_ctrl: RTL and testbench

// Control end of the one-cycle CPU: holds the PC, fetches one instruction word per cycle from a

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/ret_stack.sv | 53 +++++
 rtl/cpu_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_cpu_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared opcode map, B-operand select codes and FSM state encoding for the one-cycle CPU control path.
package cpu_pkg;

  localparam logic [5:0] OP_NOP    = 6'b110000;
  localparam logic [5:0] OP_ST_REG = 6'b110001;
  localparam logic [5:0] OP_ST_MEM = 6'b110010;
  localparam logic [5:0] OP_ST_IND = 6'b110011;
  localparam logic [5:0] OP_JMP    = 6'b110100;
  localparam logic [5:0] OP_JZ     = 6'b110101;
  localparam logic [5:0] OP_JNZ    = 6'b110110;
  localparam logic [5:0] OP_CALL   = 6'b110111;
  localparam logic [5:0] OP_RET    = 6'b111000;
  localparam logic [5:0] OP_LDI    = 6'b111001;
  localparam logic [5:0] OP_HALT   = 6'b111111;

  // opcode[5:4] groups: three ALU flavours, everything else lives in the control group
  localparam logic [1:0] GRP_ALU_IMM = 2'b00;
  localparam logic [1:0] GRP_ALU_REG = 2'b01;
  localparam logic [1:0] GRP_ALU_MEM = 2'b10;
  localparam logic [1:0] GRP_CTRL    = 2'b11;

  localparam logic [1:0] B_IMM = 2'b00;
  localparam logic [1:0] B_REG = 2'b01;
  localparam logic [1:0] B_MEM = 2'b10;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO; push/pop take effect on the clock edge, top entry is visible combinationally.
// Pushes while full and pops while empty are ignored; the caller flags them as errors.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] push_dat,
  output logic [DW-1:0] top_dat,
  output logic          full,
  output logic          empty
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0]    mem [DEPTH];
  logic [SP_W-1:0]  sp;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;
  logic             do_push;
  logic             do_pop;

  assign full    = (sp == SP_W'(DEPTH));
  assign empty   = (sp == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // sp points one past the top; truncation is safe because writes only occur below DEPTH
  assign wr_idx  = IDX_W'(sp);
  assign top_idx = IDX_W'(sp - SP_W'(1));
  assign top_dat = mem[top_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
    end else if (do_push) begin
      sp <= sp + SP_W'(1);
    end else if (do_pop) begin
      sp <= sp - SP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_idx] <= push_dat;
    end
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Control end of the one-cycle CPU: PC, zero-latency decode, branch/CALL/RET sequencing, sticky HALT.
// run=0 stalls (PC/stack frozen, enables low); only pc_rst leaves HALT.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int              WIDTH          = 8,
  parameter int              IWIDTH         = 4,
  parameter int              REG_F_SEL_SIZE = 4,
  parameter int              IN_B_SEL_SIZE  = 2,
  parameter int              PC_WIDTH       = 8,
  parameter int              STACK_DEPTH    = 4,
  parameter logic [IWIDTH-1:0] ALU_PASS_B   = 4'h1
) (
  input  logic                      clk,
  input  logic                      pc_rst,
  input  logic                      run,
  input  logic [6+WIDTH-1:0]        instr,
  input  logic                      flag_z_in,
  output logic [PC_WIDTH-1:0]       pc,
  output logic [REG_F_SEL_SIZE-1:0] reg_f_sel,
  output logic                      en_reg_f,
  output logic [WIDTH-1:0]          d_mem_addr,
  output logic                      d_mem_addr_mode,
  output logic                      en_d_mem,
  output logic [IN_B_SEL_SIZE-1:0]  in_b_sel,
  output logic [WIDTH-1:0]          imm,
  output logic [IWIDTH-1:0]         alu_out,
  output logic                      en_acc,
  output logic                      halted,
  output logic                      stack_err
);

  typedef struct packed {
    logic [REG_F_SEL_SIZE-1:0] reg_f_sel;
    logic                      en_reg_f;
    logic [WIDTH-1:0]          d_mem_addr;
    logic                      d_mem_addr_mode;
    logic                      en_d_mem;
    logic [IN_B_SEL_SIZE-1:0]  in_b_sel;
    logic [WIDTH-1:0]          imm;
    logic [IWIDTH-1:0]         alu_out;
    logic                      en_acc;
  } ctrl_t;

  logic [5:0]          opcode;
  logic [WIDTH-1:0]    operand;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] pc_target;
  state_t              state_q;
  state_t              state_d;
  logic                stack_err_q;
  logic                err_set;
  logic                exec;
  logic                push;
  logic                pop;
  logic                stk_full;
  logic                stk_empty;
  logic [PC_WIDTH-1:0] stk_top;
  ctrl_t               dec;
  ctrl_t               ctrl;

  assign {opcode, operand} = instr;
  assign pc_inc    = pc_q + PC_WIDTH'(1);
  assign pc_target = operand[PC_WIDTH-1:0];

  // an instruction only has side effects when it is allowed to retire this cycle
  assign exec = run && (state_q == S_RUN) && !pc_rst;

  always_comb begin
    dec                 = '0;
    dec.reg_f_sel       = operand[REG_F_SEL_SIZE-1:0];
    dec.d_mem_addr      = operand;
    dec.imm             = operand;
    dec.alu_out         = opcode[IWIDTH-1:0];
    dec.in_b_sel        = IN_B_SEL_SIZE'(B_IMM);
    dec.d_mem_addr_mode = 1'b0;
    case (opcode[5:4])
      GRP_ALU_IMM: dec.en_acc = 1'b1;
      GRP_ALU_REG: begin
        dec.in_b_sel = IN_B_SEL_SIZE'(B_REG);
        dec.en_acc   = 1'b1;
      end
      GRP_ALU_MEM: begin
        dec.in_b_sel = IN_B_SEL_SIZE'(B_MEM);
        dec.en_acc   = 1'b1;
      end
      GRP_CTRL: begin
        case (opcode)
          OP_NOP:    ;
          OP_ST_REG: dec.en_reg_f = 1'b1;
          OP_ST_MEM: dec.en_d_mem = 1'b1;
          OP_ST_IND: begin
            dec.en_d_mem        = 1'b1;
            dec.d_mem_addr_mode = 1'b1;
          end
          OP_LDI: begin
            dec.in_b_sel        = IN_B_SEL_SIZE'(B_MEM);
            dec.d_mem_addr_mode = 1'b1;
            dec.alu_out         = ALU_PASS_B;
            dec.en_acc          = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    ctrl = dec;
    if (!exec) begin
      ctrl.en_reg_f = 1'b0;
      ctrl.en_d_mem = 1'b0;
      ctrl.en_acc   = 1'b0;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    if (exec) begin
      pc_d = pc_inc;
      case (opcode)
        OP_JMP: pc_d = pc_target;
        OP_JZ:  if (flag_z_in)  pc_d = pc_target;
        OP_JNZ: if (!flag_z_in) pc_d = pc_target;
        OP_CALL: begin
          if (!stk_full) begin
            push = 1'b1;
            pc_d = pc_target;
          end else begin
            err_set = 1'b1;
          end
        end
        OP_RET: begin
          if (!stk_empty) begin
            pop  = 1'b1;
            pc_d = stk_top;
          end else begin
            err_set = 1'b1;
          end
        end
        OP_HALT: begin
          pc_d    = pc_q;
          state_d = S_HALT;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (pc_rst) begin
      pc_q        <= '0;
      state_q     <= S_RUN;
      stack_err_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      if (err_set) begin
        stack_err_q <= 1'b1;
      end
    end
  end

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .DW    (PC_WIDTH)
  ) u_ret_stack (
    .clk      (clk),
    .rst      (pc_rst),
    .push     (push),
    .pop      (pop),
    .push_dat (pc_inc),
    .top_dat  (stk_top),
    .full     (stk_full),
    .empty    (stk_empty)
  );

  assign pc              = pc_q;
  assign halted          = (state_q == S_HALT);
  assign stack_err       = stack_err_q;
  assign reg_f_sel       = ctrl.reg_f_sel;
  assign en_reg_f        = ctrl.en_reg_f;
  assign d_mem_addr      = ctrl.d_mem_addr;
  assign d_mem_addr_mode = ctrl.d_mem_addr_mode;
  assign en_d_mem        = ctrl.en_d_mem;
  assign in_b_sel        = ctrl.in_b_sel;
  assign imm             = ctrl.imm;
  assign alu_out         = ctrl.alu_out;
  assign en_acc          = ctrl.en_acc;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed scenarios plus randomized programs, checked every cycle against a queue-based CPU model.
module tb_cpu_ctrl;

  logic        clk;
  logic        pc_rst;
  logic        run;
  logic [13:0] instr;
  logic        flag_z_in;
  logic [7:0]  pc;
  logic [3:0]  reg_f_sel;
  logic        en_reg_f;
  logic [7:0]  d_mem_addr;
  logic        d_mem_addr_mode;
  logic        en_d_mem;
  logic [1:0]  in_b_sel;
  logic [7:0]  imm;
  logic [3:0]  alu_out;
  logic        en_acc;
  logic        halted;
  logic        stack_err;

  cpu_ctrl dut (
    .clk             (clk),
    .pc_rst          (pc_rst),
    .run             (run),
    .instr           (instr),
    .flag_z_in       (flag_z_in),
    .pc              (pc),
    .reg_f_sel       (reg_f_sel),
    .en_reg_f        (en_reg_f),
    .d_mem_addr      (d_mem_addr),
    .d_mem_addr_mode (d_mem_addr_mode),
    .en_d_mem        (en_d_mem),
    .in_b_sel        (in_b_sel),
    .imm             (imm),
    .alu_out         (alu_out),
    .en_acc          (en_acc),
    .halted          (halted),
    .stack_err       (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [13:0] rom [256];
  int m_pc   = 0;
  int m_stk[$];
  bit m_err  = 0;
  bit m_halt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h want=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // expected outputs derived from the opcode table (decimal opcodes) and the model state
  task automatic compare();
    int op, opd, exp_bsel, exp_alu;
    bit en;
    op  = int'(instr[13:8]);
    opd = int'(instr[7:0]);
    en  = !pc_rst && run && !m_halt;
    if (op < 16)       exp_bsel = 0;
    else if (op < 32)  exp_bsel = 1;
    else if (op < 48)  exp_bsel = 2;
    else if (op == 57) exp_bsel = 2;
    else               exp_bsel = 0;
    exp_alu = (op == 57) ? 1 : op % 16;
    chk("pc", int'(pc), m_pc);
    chk("halted", int'(halted), int'(m_halt));
    chk("stack_err", int'(stack_err), int'(m_err));
    chk("en_acc", int'(en_acc), int'(en && (op < 48 || op == 57)));
    chk("en_reg_f", int'(en_reg_f), int'(en && op == 49));
    chk("en_d_mem", int'(en_d_mem), int'(en && (op == 50 || op == 51)));
    chk("mode", int'(d_mem_addr_mode), int'(op == 51 || op == 57));
    chk("in_b_sel", int'(in_b_sel), exp_bsel);
    chk("alu_out", int'(alu_out), exp_alu);
    chk("imm", int'(imm), opd);
    chk("d_mem_addr", int'(d_mem_addr), opd);
    chk("reg_f_sel", int'(reg_f_sel), opd % 16);
  endtask

  task automatic model_step();
    int op, opd, npc;
    op  = int'(instr[13:8]);
    opd = int'(instr[7:0]);
    if (pc_rst) begin
      m_pc = 0;
      m_stk.delete();
      m_err  = 0;
      m_halt = 0;
      return;
    end
    if (m_halt || !run) return;
    npc = (m_pc + 1) % 256;
    case (op)
      52: npc = opd;
      53: if (flag_z_in)  npc = opd;
      54: if (!flag_z_in) npc = opd;
      55: if (m_stk.size() < 4) begin
            m_stk.push_back(npc);
            npc = opd;
          end else m_err = 1;
      56: if (m_stk.size() > 0) npc = m_stk.pop_back();
          else m_err = 1;
      63: begin
            m_halt = 1;
            npc    = m_pc;
          end
      default: ;
    endcase
    m_pc = npc;
  endtask

  task automatic drive(input bit r, input bit rn, input bit z);
    pc_rst    = r;
    run       = rn;
    flag_z_in = z;
    instr     = rom[m_pc];
    #1;
    compare();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic cyc(input bit r, input bit rn, input bit z);
    drive(r, rn, z);
    tick();
  endtask

  // first reset: DUT state is unknown, so no comparison on this cycle
  task automatic do_reset();
    pc_rst    = 1'b1;
    run       = 1'b1;
    flag_z_in = 1'b0;
    instr     = rom[m_pc];
    tick();
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = {6'b110000, 8'h00};
  endtask

  function automatic logic [13:0] rand_instr();
    int r;
    logic [5:0] op;
    r = $urandom_range(0, 99);
    if (r < 45)      op = 6'($urandom_range(0, 47));
    else if (r < 55) op = 6'($urandom_range(49, 51));
    else if (r < 65) op = 6'($urandom_range(52, 54));
    else if (r < 75) op = 6'd55;
    else if (r < 85) op = 6'd56;
    else if (r < 88) op = 6'd57;
    else if (r < 90) op = 6'd63;
    else if (r < 93) op = 6'($urandom_range(58, 62));
    else             op = 6'd48;
    return {op, 8'($urandom_range(0, 255))};
  endfunction

  int jz_exp [4] = '{32'h20, 32'h04, 32'h04, 32'h20};

  initial begin
    pc_rst = 1'b1; run = 1'b0; flag_z_in = 1'b0; instr = '0;
    @(negedge clk);

    // 1: ALU immediate at pc 0
    clear_rom();
    rom[0] = {6'b000000, 8'h05};
    do_reset();
    drive(0, 1, 0);
    chk("t1_pc0", int'(pc), 0);
    chk("t1_en_acc", int'(en_acc), 1);
    chk("t1_in_b_sel", int'(in_b_sel), 0);
    chk("t1_imm", int'(imm), 5);
    chk("t1_alu_out", int'(alu_out), 0);
    tick();
    chk("t1_pc1", int'(pc), 1);

    // 2: JZ / JNZ at pc 3, both flag values
    for (int k = 0; k < 4; k++) begin
      clear_rom();
      rom[3] = {(k < 2) ? 6'b110101 : 6'b110110, 8'h20};
      do_reset();
      for (int i = 0; i < 3; i++) cyc(0, 1, 0);
      cyc(0, 1, (k % 2) == 0);
      chk("t2_branch_pc", int'(pc), jz_exp[k]);
    end

    // 3: CALL/RET round trip, then nesting past the stack depth
    clear_rom();
    rom[2]    = {6'b110111, 8'h10};
    rom[8'h10] = {6'b111000, 8'h00};
    do_reset();
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    chk("t3_call_pc", int'(pc), 8'h10);
    cyc(0, 1, 0);
    chk("t3_ret_pc", int'(pc), 3);
    clear_rom();
    rom[0] = {6'b110100, 8'h50};
    for (int i = 0; i < 4; i++) rom[8'h50 + i] = {6'b110111, 8'(8'h51 + i)};
    rom[8'h54] = {6'b110111, 8'h60};
    do_reset();
    for (int i = 0; i < 5; i++) cyc(0, 1, 0);
    chk("t3_depth4_pc", int'(pc), 8'h54);
    chk("t3_depth4_err", int'(stack_err), 0);
    cyc(0, 1, 0);
    chk("t3_overflow_pc", int'(pc), 8'h55);
    chk("t3_overflow_err", int'(stack_err), 1);

    // 4: RET on empty stack, sticky error
    clear_rom();
    rom[0] = {6'b111000, 8'h00};
    do_reset();
    cyc(0, 1, 0);
    chk("t4_pc", int'(pc), 1);
    chk("t4_err", int'(stack_err), 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0);
    chk("t4_err_held", int'(stack_err), 1);
    cyc(1, 1, 0);
    chk("t4_err_clr", int'(stack_err), 0);

    // 5: HALT at pc 7 is sticky until reset
    clear_rom();
    rom[0] = {6'b110100, 8'h07};
    rom[7] = {6'b111111, 8'h00};
    do_reset();
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 0);
      chk("t5_halted", int'(halted), 1);
      chk("t5_pc", int'(pc), 7);
      chk("t5_enables", int'({en_acc, en_reg_f, en_d_mem}), 0);
      tick();
    end
    cyc(1, 1, 0);
    chk("t5_rst_pc", int'(pc), 0);
    chk("t5_rst_halted", int'(halted), 0);

    // 6: stall on indirect store, then PC wrap
    clear_rom();
    rom[0] = {6'b110011, 8'h33};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0);
      chk("t6_stall_en", int'(en_d_mem), 0);
      tick();
      chk("t6_stall_pc", int'(pc), 0);
    end
    drive(0, 1, 0);
    chk("t6_en_d_mem", int'(en_d_mem), 1);
    chk("t6_mode", int'(d_mem_addr_mode), 1);
    tick();
    clear_rom();
    rom[0] = {6'b110100, 8'hFF};
    do_reset();
    cyc(0, 1, 0);
    chk("t6_pc_ff", int'(pc), 8'hFF);
    cyc(0, 1, 0);
    chk("t6_pc_wrap", int'(pc), 0);

    // random programs, stalls, flags and occasional resets
    for (int i = 0; i < 256; i++) rom[i] = rand_instr();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 85, $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
